// File: rtl/board_mem_arbiter.sv
// Port-B arbiter for the board image RAM: display reader has priority,
// processor gets a guaranteed slot after a bounded wait.
module board_mem_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 16,
    parameter int RD_LAT       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic [3:0]        p_be,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    output logic [ADDR_W-1:0] address_b,
    output logic [DATA_W-1:0] data_b,
    output logic              wren_b,
    output logic [3:0]        byteena_b,
    input  logic [DATA_W-1:0] q_b
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIMIT);
    localparam logic GUARD_ON = (STARVE_LIMIT != 0);

    logic [CNT_W-1:0]  r_wait_cnt;
    logic [ADDR_W-1:0] r_address_b;
    logic [DATA_W-1:0] r_data_b;
    logic              r_wren_b;
    logic [3:0]        r_byteena_b;
    logic [RD_LAT:0]   r_tag_v;
    logic [RD_LAT:0]   r_tag_p;

    logic w_starve;
    logic w_d_gnt;
    logic w_p_gnt;
    logic w_rd_acc;

    assign w_starve = p_req && GUARD_ON && (r_wait_cnt >= CNT_LIM);

    always_comb begin
        w_d_gnt = 1'b0;
        w_p_gnt = 1'b0;
        if (!rst) begin
            if (w_starve) begin
                w_p_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end else if (p_req) begin
                w_p_gnt = 1'b1;
            end
        end
    end

    assign d_gnt    = w_d_gnt;
    assign p_gnt    = w_p_gnt;
    assign w_rd_acc = w_d_gnt || (w_p_gnt && !p_we);

    // Saturating wait counter; only counts while the processor is held off
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!p_req || w_p_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_address_b <= '0;
            r_data_b    <= '0;
            r_wren_b    <= 1'b0;
            r_byteena_b <= 4'h0;
        end else if (w_d_gnt) begin
            r_address_b <= d_addr;
            r_wren_b    <= 1'b0;
            r_byteena_b <= 4'hF;
        end else if (w_p_gnt && p_we) begin
            r_address_b <= p_addr;
            r_data_b    <= p_wdata;
            r_wren_b    <= 1'b1;
            r_byteena_b <= p_be;
        end else if (w_p_gnt) begin
            r_address_b <= p_addr;
            r_wren_b    <= 1'b0;
            r_byteena_b <= 4'hF;
        end else begin
            r_wren_b    <= 1'b0;
            r_byteena_b <= 4'h0;
        end
    end

    assign address_b = r_address_b;
    assign data_b    = r_data_b;
    assign wren_b    = r_wren_b;
    assign byteena_b = r_byteena_b;

    // Stage 0 lines up with the port-B cycle, the last stage with q_b
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            r_tag_p <= '0;
        end else begin
            r_tag_v[0] <= w_rd_acc;
            r_tag_p[0] <= w_p_gnt;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_p[i] <= r_tag_p[i-1];
            end
        end
    end

    assign d_rvalid = r_tag_v[RD_LAT] && !r_tag_p[RD_LAT];
    assign p_rvalid = r_tag_v[RD_LAT] && r_tag_p[RD_LAT];
    assign d_rdata  = q_b;
    assign p_rdata  = q_b;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: directed vector table, hand sequences
// and randomized traffic against a transaction-level reference model.
module tb_board_mem_arbiter;

    localparam int AW  = 17;
    localparam int DW  = 32;
    localparam int LIM = 16;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [3:0]    p_be;
    logic          p_gnt;
    logic          p_rvalid;
    logic [DW-1:0] p_rdata;
    logic [AW-1:0] address_b;
    logic [DW-1:0] data_b;
    logic          wren_b;
    logic [3:0]    byteena_b;
    logic [DW-1:0] q_b;

    board_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_be(p_be), .p_gnt(p_gnt),
        .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b),
        .byteena_b(byteena_b), .q_b(q_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'(a * 50);
    endfunction

    // RAM port B with one cycle read latency, read-before-write
    logic [31:0] ram [int];
    function automatic logic [31:0] ram_rd(input int a);
        if (ram.exists(a)) return ram[a];
        return pat(a);
    endfunction
    always @(posedge clk) begin
        logic [31:0] w;
        q_b <= ram_rd(int'(address_b));
        if (wren_b === 1'b1) begin
            w = ram_rd(int'(address_b));
            for (int b = 0; b < 4; b++)
                if (byteena_b[b]) w[b*8 +: 8] = data_b[b*8 +: 8];
            ram[int'(address_b)] = w;
        end
    end

    // Reference model state
    logic [31:0] shd [int];
    function automatic logic [31:0] shd_rd(input int a);
        if (shd.exists(a)) return shd[a];
        return pat(a);
    endfunction

    typedef struct {
        int          due;
        bit          own;
        logic [31:0] data;
    } ret_t;
    ret_t rq[$];

    int            cyc = 0;
    int            wcnt = 0;
    bit            known = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic          e_wren = 1'b0;
    logic [3:0]    e_be = 4'h0;

    logic          s_dg, s_pg, s_wren, s_drv, s_prv;
    logic [AW-1:0] s_addr;
    logic [3:0]    s_be;
    logic [DW-1:0] s_data, s_drd, s_prd;

    // Inputs are set at negedge; sample, check, advance model, next negedge
    task automatic cycle();
        logic eg_d, eg_p, ev_d, ev_p;
        logic [31:0] edat, w;
        #1;
        s_dg = d_gnt;   s_pg = p_gnt;
        s_addr = address_b; s_be = byteena_b;
        s_wren = wren_b; s_data = data_b;
        s_drv = d_rvalid; s_prv = p_rvalid;
        s_drd = d_rdata;  s_prd = p_rdata;
        eg_d = 1'b0; eg_p = 1'b0;
        if (!rst) begin
            if (p_req && LIM != 0 && wcnt >= LIM) eg_p = 1'b1;
            else if (d_req) eg_d = 1'b1;
            else if (p_req) eg_p = 1'b1;
        end
        chk("d_gnt", s_dg, eg_d);
        chk("p_gnt", s_pg, eg_p);
        ev_d = 1'b0; ev_p = 1'b0; edat = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev_d = !rq[0].own;
            ev_p = rq[0].own;
            edat = rq[0].data;
            void'(rq.pop_front());
        end
        if (known) begin
            chk("address_b", s_addr, e_addr);
            chk("data_b", s_data, e_data);
            chk("wren_b", s_wren, e_wren);
            chk("byteena_b", s_be, e_be);
            chk("d_rvalid", s_drv, ev_d);
            chk("p_rvalid", s_prv, ev_p);
            if (ev_d) chk("d_rdata", s_drd, edat);
            if (ev_p) chk("p_rdata", s_prd, edat);
        end
        if (rst) begin
            wcnt = 0;
            e_addr = '0; e_data = '0; e_wren = 1'b0; e_be = 4'h0;
            rq.delete();
        end else begin
            wcnt = (p_req && !eg_p) ? wcnt + 1 : 0;
            if (eg_d) begin
                e_addr = d_addr; e_be = 4'hF; e_wren = 1'b0;
                rq.push_back('{cyc + 1 + LAT, 1'b0, shd_rd(int'(d_addr))});
            end else if (eg_p && p_we) begin
                e_addr = p_addr; e_data = p_wdata;
                e_be = p_be; e_wren = 1'b1;
                w = shd_rd(int'(p_addr));
                for (int b = 0; b < 4; b++)
                    if (p_be[b]) w[b*8 +: 8] = p_wdata[b*8 +: 8];
                shd[int'(p_addr)] = w;
            end else if (eg_p) begin
                e_addr = p_addr; e_be = 4'hF; e_wren = 1'b0;
                rq.push_back('{cyc + 1 + LAT, 1'b1, shd_rd(int'(p_addr))});
            end else begin
                e_wren = 1'b0; e_be = 4'h0;
            end
        end
        known = 1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        d_req = 1'b0; p_req = 1'b0; p_we = 1'b0;
    endtask

    typedef struct {
        logic          dq, pq, pwe;
        logic [AW-1:0] da, pa;
        logic [DW-1:0] pwd;
        logic [3:0]    pbe;
        logic          eg_d, eg_p;
        logic [AW-1:0] eaddr;
        logic [3:0]    ebe;
        logic          ewren;
        logic          cdat;
        logic [DW-1:0] edat;
        logic          erd, erp;
        logic [DW-1:0] erdata;
    } vec_t;

    vec_t vt[8];
    logic [2:0] alt_rv [3];
    logic [31:0] alt_rd [3];
    bit d_pend, p_pend;

    initial begin
        vt[0] = '{1,0,0, 17'h2,     17'h0,     32'h0,        4'h0, 1,0, 17'h2,     4'hF, 0, 0, 32'h0,        1,0, 32'h64};
        vt[1] = '{0,1,1, 17'h0,     17'h1FFFF, 32'hDEADBEEF, 4'h3, 0,1, 17'h1FFFF, 4'h3, 1, 1, 32'hDEADBEEF, 0,0, 32'h0};
        vt[2] = '{0,1,0, 17'h0,     17'h1FFFF, 32'h0,        4'h0, 0,1, 17'h1FFFF, 4'hF, 0, 0, 32'h0,        0,1, 32'h0063BEEF};
        vt[3] = '{1,0,0, 17'h10,    17'h0,     32'h0,        4'h0, 1,0, 17'h10,    4'hF, 0, 0, 32'h0,        1,0, 32'h320};
        vt[4] = '{0,1,1, 17'h0,     17'h5,     32'h12345678, 4'h0, 0,1, 17'h5,     4'h0, 1, 1, 32'h12345678, 0,0, 32'h0};
        vt[5] = '{0,1,0, 17'h0,     17'h5,     32'h0,        4'h0, 0,1, 17'h5,     4'hF, 0, 0, 32'h0,        0,1, 32'hFA};
        vt[6] = '{0,1,1, 17'h0,     17'h5,     32'hAABBCCDD, 4'h8, 0,1, 17'h5,     4'h8, 1, 1, 32'hAABBCCDD, 0,0, 32'h0};
        vt[7] = '{1,0,0, 17'h5,     17'h0,     32'h0,        4'h0, 1,0, 17'h5,     4'hF, 0, 0, 32'h0,        1,0, 32'hAA0000FA};

        rst = 1'b1; d_req = 1'b1; p_req = 1'b1; p_we = 1'b0;
        d_addr = 17'h7; p_addr = 17'h9; p_wdata = '0; p_be = 4'h0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst d_gnt", s_dg, 1'b0);
            chk("rst p_gnt", s_pg, 1'b0);
            if (i > 0) begin
                chk("rst wren_b", s_wren, 1'b0);
                chk("rst address_b", s_addr, '0);
                chk("rst byteena_b", s_be, 4'h0);
            end
        end
        rst = 1'b0; idle();
        cycle();

        foreach (vt[i]) begin
            d_req = vt[i].dq; d_addr = vt[i].da;
            p_req = vt[i].pq; p_we = vt[i].pwe; p_addr = vt[i].pa;
            p_wdata = vt[i].pwd; p_be = vt[i].pbe;
            cycle();
            chk($sformatf("v%0d d_gnt", i), s_dg, vt[i].eg_d);
            chk($sformatf("v%0d p_gnt", i), s_pg, vt[i].eg_p);
            idle();
            cycle();
            chk($sformatf("v%0d address_b", i), s_addr, vt[i].eaddr);
            chk($sformatf("v%0d byteena_b", i), s_be, vt[i].ebe);
            chk($sformatf("v%0d wren_b", i), s_wren, vt[i].ewren);
            if (vt[i].cdat) chk($sformatf("v%0d data_b", i), s_data, vt[i].edat);
            cycle();
            chk($sformatf("v%0d wren_b T+2", i), s_wren, 1'b0);
            chk($sformatf("v%0d d_rvalid", i), s_drv, vt[i].erd);
            chk($sformatf("v%0d p_rvalid", i), s_prv, vt[i].erp);
            if (vt[i].erd) chk($sformatf("v%0d d_rdata", i), s_drd, vt[i].erdata);
            if (vt[i].erp) chk($sformatf("v%0d p_rdata", i), s_prd, vt[i].erdata);
            cycle();
        end

        // Starvation guard: display saturates the port, processor waits
        idle(); cycle();
        p_we = 1'b0;
        for (int k = 0; k < 34; k++) begin
            d_req = 1'b1; d_addr = AW'(k);
            p_req = 1'b1; p_addr = (k < 17) ? 17'h40 : 17'h41;
            cycle();
            chk($sformatf("starve d_gnt c%0d", k), s_dg, !(k == 16 || k == 33));
            chk($sformatf("starve p_gnt c%0d", k), s_pg, (k == 16 || k == 33));
        end
        idle();
        repeat (3) cycle();

        // Alternating owners on consecutive cycles
        d_req = 1'b1; d_addr = 17'h10; cycle();
        d_req = 1'b0; p_req = 1'b1; p_we = 1'b0; p_addr = 17'h20; cycle();
        p_req = 1'b0; d_req = 1'b1; d_addr = 17'h30; cycle();
        alt_rv[0] = {s_drv, s_prv, 1'b0}; alt_rd[0] = s_drd;
        idle(); cycle();
        alt_rv[1] = {s_drv, s_prv, 1'b0}; alt_rd[1] = s_prd;
        cycle();
        alt_rv[2] = {s_drv, s_prv, 1'b0}; alt_rd[2] = s_drd;
        chk("alt rv0", alt_rv[0], 3'b100);
        chk("alt rv1", alt_rv[1], 3'b010);
        chk("alt rv2", alt_rv[2], 3'b100);
        chk("alt rd0", alt_rd[0], 32'h320);
        chk("alt rd1", alt_rd[1], 32'h640);
        chk("alt rd2", alt_rd[2], 32'h960);
        cycle();

        // Reset with a read in flight
        d_req = 1'b1; d_addr = 17'h2; cycle();
        chk("mid d_gnt", s_dg, 1'b1);
        idle(); rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        chk("mid d_rvalid T+2", s_drv, 1'b0);
        cycle();
        chk("mid d_rvalid T+3", s_drv, 1'b0);
        d_req = 1'b1; d_addr = 17'h2; cycle();
        chk("post d_gnt", s_dg, 1'b1);
        idle(); cycle();
        chk("post address_b", s_addr, 17'h2);
        chk("post byteena_b", s_be, 4'hF);
        cycle();
        chk("post d_rvalid", s_drv, 1'b1);
        chk("post d_rdata", s_drd, 32'h64);
        chk("post p_rvalid", s_prv, 1'b0);

        // Randomized traffic against the model
        d_pend = 0; p_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 255) == 0);
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1;
                d_addr = AW'($urandom_range(0, 63));
            end
            if (!p_pend && $urandom_range(0, 2) == 0) begin
                p_pend = 1;
                p_we = 1'($urandom_range(0, 1));
                p_addr = AW'($urandom_range(0, 63));
                p_wdata = $urandom;
                p_be = 4'($urandom_range(0, 15));
            end
            d_req = d_pend; p_req = p_pend;
            cycle();
            if (s_dg) d_pend = 0;
            if (s_pg) p_pend = 0;
        end
        rst = 1'b0; idle();
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Shares port B of the board image RAM between two requesters: the `draw_board` display reader and the PISA processor/load path. The display reader fetches the header words (width, height) and pixel words. Display reads have priority. A starvation guard gives the processor a slot after a bounded wait. The block drives the RAM port-B signals, tags every read, and returns read data to the requester that issued it.

## Interface
- `ADDR_W`, 17, word address width of port B
- `DATA_W`, 32, data width of port B
- `STARVE_LIMIT`, 16, processor wait cycles before it preempts the display; 0 disables the guard (strict display priority)
- `RD_LAT`, 1, RAM read latency in cycles from address presented on port B to valid `q_b`

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `d_req`  in  1  display read request
- `d_addr`  in  ADDR_W  display read word address
- `d_gnt`  out  1  display request accepted this cycle
- `d_rvalid`  out  1  `d_rdata` valid
- `d_rdata`  out  DATA_W  display read data
- `p_req`  in  1  processor request
- `p_we`  in  1  1 = write, 0 = read
- `p_addr`  in  ADDR_W  processor word address
- `p_wdata`  in  DATA_W  processor write data
- `p_be`  in  4  processor byte enables (writes)
- `p_gnt`  out  1  processor request accepted this cycle
- `p_rvalid`  out  1  `p_rdata` valid
- `p_rdata`  out  DATA_W  processor read data
- `address_b`  out  ADDR_W  RAM port-B address
- `data_b`  out  DATA_W  RAM port-B write data
- `wren_b`  out  1  RAM port-B write enable
- `byteena_b`  out  4  RAM port-B byte enables
- `q_b`  in  DATA_W  RAM port-B read data

## Operation
- Handshake:
  - A requester holds `req` and all its request fields stable until it sees `gnt`.
  - A transfer occurs on the rising edge where `req && gnt`.
  - `gnt` is combinational from the `req` inputs, `wait_cnt` and `rst`.
  - At most one grant per cycle.
- Grant decision per cycle:
  - If `rst`: no grant.
  - Else if `p_req` and `STARVE_LIMIT != 0` and `wait_cnt >= STARVE_LIMIT`: `p_gnt`.
  - Else if `d_req`: `d_gnt`.
  - Else if `p_req`: `p_gnt`.
- `wait_cnt` (`$clog2(STARVE_LIMIT+1)` bits, saturating):
  - Increments each cycle `p_req && !p_gnt`.
  - Clears on `p_gnt` or when `p_req` is low.
  - Never wraps.
- Port-B drive, registered in the cycle after a grant:
  - Display grant: `address_b=d_addr`, `byteena_b=4'hF`, `wren_b=0`.
  - Processor read: `address_b=p_addr`, `byteena_b=4'hF`, `wren_b=0`.
  - Processor write: `address_b=p_addr`, `data_b=p_wdata`, `byteena_b=p_be`, `wren_b=1`.
  - No grant: `wren_b=0`, `byteena_b=0`, `address_b`/`data_b` hold their previous value.
- Read tagging:
  - A tag pipeline of depth `RD_LAT+1` carries {valid, owner} per accepted read.
  - Writes enter no tag.
- Data return:
  - `d_rdata` and `p_rdata` both equal `q_b` combinationally.
  - Only the matching `rvalid` asserts, for exactly one cycle per read.
- Byte-enable value 0 on a processor write is passed through (RAM no-op). No special case.

## Timing
- Read accepted at edge of cycle T:
  - Port-B signals are valid in cycle T+1.
  - `rvalid` is high in cycle T+1+`RD_LAT` (T+2 at default).
- Write accepted at cycle T: `wren_b` is high only in cycle T+1.
- Back-to-back grants give full throughput: one access per cycle, reads returned in issue order.
- Reset values (cycle after `rst` sampled high):
  - `address_b=0`, `data_b=0`, `wren_b=0`, `byteena_b=0`.
  - `d_rvalid=p_rvalid=0`, tag pipeline cleared, `wait_cnt=0`.
  - `d_gnt=p_gnt=0` while `rst` is high.
- Reset mid-operation: in-flight reads are discarded. No `rvalid` may appear for a request accepted before reset.
- Simultaneous `d_req`/`p_req`, guard not triggered: the display wins and `wait_cnt` increments.

## Test plan
- Reset: `rst` high 3 cycles with `d_req=p_req=1` -> `d_gnt=p_gnt=0`, `wren_b=0`, `address_b=0`, `byteena_b=0` throughout.
- Display read `d_addr=17'h00002` accepted at T, RAM model returns `32'h00000064` -> `address_b=2`, `byteena_b=4'hF`, `wren_b=0` at T+1; `d_rvalid=1`, `d_rdata=32'h64` at T+2; `p_rvalid` stays 0.
- Processor write `p_addr=17'h1FFFF`, `p_wdata=32'hDEADBEEF`, `p_be=4'b0011` -> `wren_b=1` only at T+1 with those values; no `rvalid` ever.
- Contention with `STARVE_LIMIT=16`, `d_req` held high, `p_req` raised at cycle 0 -> `d_gnt` in cycles 0-15, `p_gnt=1`/`d_gnt=0` at cycle 16, `d_gnt` again at 17, `wait_cnt` back to 0.
- Alternating reads D@0x10, P@0x20, D@0x30 on consecutive cycles -> `rvalid` pulses on D, P, D in consecutive cycles, each `q_b` matching its address; no cross-delivery.
- Read accepted at T, `rst=1` at T+1 -> `d_rvalid=0` at T+2 and after; the next grant after reset release behaves as in the display-read scenario.
